// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Instruction fetch front end that sits just before the IF/ID register.
//   Issues word fetches to instruction memory, keeps the returned words with
//   their PCs in a small first-word-fall-through prefetch FIFO, and hands
//   them to decode over valid/ready. A redirect flushes the FIFO and marks
//   every still-unanswered request so that its late response is discarded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   redirect_valid    redirect the fetch stream this cycle
//   redirect_pc       new fetch PC (bits [1:0] forced to 00)
//   imem_req/addr     fetch request and byte address of the requested word
//   imem_ready        memory accepts the request
//   imem_rvalid/rdata in-order response, one per accepted request
//   id_valid/ready    handshake towards decode
//   id_instr/id_pc    head instruction and its PC (NOP / 0 when not valid)
module riscv_fetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam int          OW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [OW-1:0] out_after_rsp;
    logic [31:0]   redirect_aligned;
    logic          unused_lsbs;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign unused_lsbs      = ^redirect_pc[1:0];

    // A response with nothing outstanding is spurious and ignored entirely.
    assign rsp_live = imem_rvalid && (outstanding != '0);
    // While discard is nonzero the in-order response belongs to a flushed stream.
    assign rsp_drop = rsp_live && (discard != '0);
    assign push     = rsp_live && (discard == '0) && !redirect_valid;

    // count + outstanding bounds the FIFO so a push can never find it full.
    assign imem_req = rst_n && !redirect_valid
                      && ((int'(count) + int'(outstanding)) < DEPTH)
                      && (int'(outstanding) < MAX_OUTSTANDING);
    assign imem_addr = fetch_pc;
    assign xfer      = imem_req && imem_ready;

    assign id_valid  = (count != '0) && !redirect_valid;
    assign pop       = id_valid && id_ready;
    assign id_instr  = id_valid ? instr_mem[rd_ptr] : NOP;
    assign id_pc     = id_valid ? pc_mem[rd_ptr]    : 32'h0;

    assign out_after_rsp = outstanding - OW'(rsp_live);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still unanswered after this cycle's response is stale.
            fetch_pc    <= redirect_aligned;
            resp_pc     <= redirect_aligned;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= out_after_rsp;
            discard     <= out_after_rsp;
        end else begin
            if (xfer) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= out_after_rsp + OW'(xfer);
            if (rsp_drop) begin
                discard <= discard - OW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    // Model: memory keeps accepted requests (tagged with the stream epoch
    // they belong to); the delivered stream is the in-order list of answers
    // from the current epoch that have not yet been taken by decode.
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_fetch = 32'h0;
    int          epoch = 0, k = 0, last_due = 0, mem_lat = 1;
    bit          rand_lat = 0, rand_rdy = 0, spur_next = 0;
    int          passed = 0, total = 0;

    bit          c_redir, c_xfer, c_rv, c_fromq, c_pop;
    logic [31:0] c_rpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, k);
    endtask

    task automatic sample();
        bit          ev;
        logic [31:0] epc, ein;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= k) begin
            imem_rvalid = 1'b1; imem_rdata = pend[0].addr ^ KEY; c_fromq = 1;
        end else if (spur_next) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; c_fromq = 0; spur_next = 0;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom; c_fromq = 0;
        end
        imem_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
        ev  = (mq.size() != 0) && !redirect_valid;
        epc = ev ? mq[0].pc : 32'h0;
        ein = ev ? mq[0].instr : NOP;
        chk("imem_req", 32'(imem_req),
            32'(!redirect_valid && (mq.size() + pend.size() < DEPTH) && (pend.size() < MAXO)));
        chk("imem_addr", imem_addr, m_fetch);
        chk("id_valid", 32'(id_valid), 32'(ev));
        chk("id_pc", id_pc, epc);
        chk("id_instr", id_instr, ein);
        chk("outstanding_bound", 32'(pend.size() <= MAXO), 32'd1);
        chk("count_bound", 32'(mq.size() <= DEPTH), 32'd1);
        c_redir = redirect_valid; c_rpc = redirect_pc;
        c_xfer  = imem_req && imem_ready;
        c_rv    = imem_rvalid;
        c_pop   = id_valid && id_ready;
    endtask

    task automatic step_edge();
        req_t r;
        bit   got;
        int   due;
        @(posedge clk);
        #1;
        got = 0;
        if (c_rv && c_fromq) begin r = pend.pop_front(); got = 1; end
        if (c_redir) begin
            mq.delete();
            m_fetch = {c_rpc[31:2], 2'b00};
            epoch++;
        end else begin
            if (c_pop && mq.size() > 0) void'(mq.pop_front());
            if (got && r.epoch == epoch) mq.push_back('{pc: r.addr, instr: r.addr ^ KEY});
            if (c_xfer) begin
                due = k + (rand_lat ? int'($urandom_range(1, 5)) : mem_lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: m_fetch, epoch: epoch, due: due});
                m_fetch = m_fetch + 32'd4;
            end
        end
        k++;
    endtask

    task automatic cyc();
        sample();
        step_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend.delete(); mq.delete();
        m_fetch = 32'h0; epoch++; last_due = k;
        spur_next = 1;
    endtask

    // Waits (bounded) for the next id_valid cycle and pins its pc/instr.
    task automatic expect_next(input string name, input logic [31:0] pc);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            sample();
            if (id_valid) begin
                seen = 1;
                chk({name, "_pc"}, id_pc, pc);
                chk({name, "_instr"}, id_instr, pc ^ KEY);
            end
            step_edge();
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, got;

        // 1: streaming, one instruction per cycle from the third cycle
        do_reset();
        mem_lat = 1; id_ready = 1'b1;
        cyc(); cyc();
        sample();
        chk("t1_first_valid", 32'(id_valid), 32'd1);
        chk("t1_first_pc", id_pc, 32'h0);
        chk("t1_first_instr", id_instr, 32'hA5A5_0000);
        step_edge();
        for (int i = 1; i < 8; i++) begin
            sample();
            chk("t1_stream_valid", 32'(id_valid), 32'd1);
            chk("t1_stream_pc", id_pc, 32'(i * 4));
            step_edge();
        end

        // 2: decode stalled, FIFO fills and fetch stops
        do_reset();
        id_ready = 1'b0;
        repeat (20) cyc();
        sample();
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_head_pc", id_pc, 32'h0);
        chk("t2_head_instr", id_instr, 32'hA5A5_0000);
        step_edge();
        id_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            sample();
            if (id_valid) begin
                chk("t2_order", id_pc, 32'(got * 4));
                got++;
            end
            step_edge();
        end
        chk("t2_delivered", 32'(got), 32'd8);

        // 3: redirect with two slow requests in flight
        do_reset();
        mem_lat = 3; id_ready = 1'b1;
        n = 0;
        while (n < 30 && !(pend.size() == 2 && pend[0].addr == 32'h8)) begin
            cyc(); n++;
        end
        chk("t3_setup", 32'(pend.size() == 2 && pend[0].addr == 32'h8), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        sample();
        chk("t3_addr_after", imem_addr, 32'h0000_0100);
        step_edge();
        expect_next("t3_target", 32'h0000_0100);

        // 4: redirect colliding with a response and a pop, then back-to-back
        mem_lat = 1;
        repeat (8) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        sample();
        chk("t4_valid_low", 32'(id_valid), 32'd0);
        chk("t4_req_low", 32'(imem_req), 32'd0);
        step_edge();
        redirect_valid = 1'b0;
        expect_next("t4_target", 32'h0000_0200);
        repeat (6) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        cyc();
        redirect_pc = 32'h0000_0406;
        cyc();
        redirect_valid = 1'b0;
        expect_next("t4_b2b", 32'h0000_0404);

        // 5: reset in the middle of a stalled slow stream
        mem_lat = 3; id_ready = 1'b0;
        repeat (8) cyc();
        do_reset();
        mem_lat = 1; id_ready = 1'b1;
        expect_next("t5_restart", 32'h0);

        // 6: random ready/latency/redirects
        rand_lat = 1; rand_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1; redirect_pc = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            cyc();
        end
        redirect_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
